// File: rtl/sevenseg_scan.sv
// +-----------------------------------------------------------------------------+
// | sevenseg_scan: 4-digit multiplexed seven-segment scanner with frame-aligned  |
// | display updates. Optional PWM dimming under macro SEVENSEG_BRIGHTNESS_EN.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sevenseg_scan #(
    parameter int DIGIT_CYCLES = 2500,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_value,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  digit_en,
`ifdef SEVENSEG_BRIGHTNESS_EN
    input  logic [3:0]  bright,
`endif
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start,
    output logic        updated
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [1:0]    digit, digit_next;
    logic          slot_end, boundary;

    logic [15:0]   display, pending;
    logic [3:0]    display_dp, pending_dp;
    logic          pending_valid;

    logic [3:0]    nibble;
    logic          lit;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic          dp_next;

`ifdef SEVENSEG_BRIGHTNESS_EN
    logic [3:0]    phase;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            count <= '0;
            digit <= 2'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            digit <= digit_next;
        end
    end

    // Next-state logic plus the values the output registers capture this edge.
    always_comb begin
        slot_end   = (count == LAST_COUNT);
        boundary   = slot_end && (digit == 2'd3);
        count_next = slot_end ? '0 : count + CW'(1);
        digit_next = slot_end ? digit + 2'd1 : digit;
        state_next = (count_next < BLANK_END) ? BLANK : DRIVE;

        nibble = display[{digit, 2'b00} +: 4];
        lit    = (state == DRIVE) && digit_en[digit];
`ifdef SEVENSEG_BRIGHTNESS_EN
        lit    = lit && (phase <= bright);
`endif
        seg_next = 7'h7F;
        an_next  = 4'hF;
        dp_next  = 1'b1;
        if (lit) begin
            seg_next = hex7(nibble);
            an_next  = ~(4'b0001 << digit);
            dp_next  = ~display_dp[digit];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= 7'h7F;
            an          <= 4'hF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_next;
            an          <= an_next;
            dp          <= dp_next;
            frame_start <= (count == '0) && (digit == 2'd0);
        end
    end

    // A write on the boundary edge bypasses the pending register entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display       <= 16'h0000;
            display_dp    <= 4'h0;
            pending       <= 16'h0000;
            pending_dp    <= 4'h0;
            pending_valid <= 1'b0;
            updated       <= 1'b0;
        end else begin
            updated <= boundary && (wr_en || pending_valid);
            if (boundary && wr_en) begin
                display       <= wr_value;
                display_dp    <= wr_dp;
                pending_valid <= 1'b0;
            end else if (boundary && pending_valid) begin
                display       <= pending;
                display_dp    <= pending_dp;
                pending_valid <= 1'b0;
            end else if (wr_en) begin
                pending       <= wr_value;
                pending_dp    <= wr_dp;
                pending_valid <= 1'b1;
            end
        end
    end

`ifdef SEVENSEG_BRIGHTNESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 4'h0;
        end else if (state == BLANK) begin
            phase <= 4'h0;
        end else begin
            phase <= phase + 4'h1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
// +-----------------------------------------------------------------------------+
// | tb_sevenseg_scan: directed scoreboard bench for sevenseg_scan (20/4 cycles). |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_sevenseg_scan;

    localparam int DC = 20;
    localparam int BC = 4;
    localparam int FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_value = 16'h0000;
    logic [3:0]  wr_dp = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    logic        updated;
`ifdef SEVENSEG_BRIGHTNESS_EN
    logic [3:0]  bright = 4'hF;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpm;
        logic [3:0]  en;
    } frame_t;

    frame_t     sb[$];
    logic [6:0] hex_tab [16];

    sevenseg_scan #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_value   (wr_value),
        .wr_dp      (wr_dp),
        .digit_en   (digit_en),
`ifdef SEVENSEG_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start),
        .updated    (updated)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, " an"},  {4'h0, an},  8'h0F);
        check({tag, " seg"}, {1'b0, seg}, 8'h7F);
        check({tag, " dp"},  {7'h0, dp},  8'h01);
    endtask

    // One full frame starting at the negedge after digit 0's first blank edge.
    // Writes are driven after the compare at positions wp1/wp2; rst_pos cuts the frame short.
    task automatic run_frame(input int id, input int wp1, input logic [15:0] v1,
                             input int wp2, input logic [15:0] v2, input logic [3:0] wd,
                             input bit exp_upd, input int rst_pos);
        frame_t     e;
        int         k, s;
        bit         lit;
        logic [3:0] nib, an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        string      tag;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard empty at frame %0d", id);
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        for (int p = 0; p < FRAME; p++) begin
            @(negedge clk);
            k       = p / DC;
            s       = p % DC;
            lit     = (s >= BC) && e.en[k];
            nib     = e.value[4*k +: 4];
            an_exp  = lit ? ~(4'b0001 << k) : 4'hF;
            seg_exp = lit ? hex_tab[nib] : 7'h7F;
            dp_exp  = lit ? ~e.dpm[k] : 1'b1;
            tag     = $sformatf("f%0d p%0d", id, p);
            check({tag, " an"},          {4'h0, an},          {4'h0, an_exp});
            check({tag, " seg"},         {1'b0, seg},         {1'b0, seg_exp});
            check({tag, " dp"},          {7'h0, dp},          {7'h0, dp_exp});
            check({tag, " frame_start"}, {7'h0, frame_start}, {7'h0, (p == 0)});
            check({tag, " updated"},     {7'h0, updated},     {7'h0, (exp_upd && p == FRAME - 1)});
            if (p == rst_pos) begin
                rst = 1'b1;
                #1;
                check_blank({tag, " async rst"});
                return;
            end
            wr_en = 1'b0;
            if (p == wp1) begin
                wr_en = 1'b1; wr_value = v1; wr_dp = wd;
            end
            if (p == wp2) begin
                wr_en = 1'b1; wr_value = v2; wr_dp = wd;
            end
        end
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        repeat (3) @(negedge clk);
        check_blank("reset");
        check("reset frame_start", {7'h0, frame_start}, 8'h00);
        check("reset updated",     {7'h0, updated},     8'h00);

        sb.push_back('{value: 16'h0000, dpm: 4'h0, en: 4'hF});
        rst = 1'b0;

        sb.push_back('{value: 16'h0000, dpm: 4'h0, en: 4'hF});
        run_frame(0, 5, 16'h0000, -1, 16'h0000, 4'h0, 1'b1, -1);

        sb.push_back('{value: 16'hF08A, dpm: 4'h0, en: 4'hF});
        run_frame(1, 40, 16'hF08A, -1, 16'h0000, 4'h0, 1'b1, -1);

        sb.push_back('{value: 16'h2222, dpm: 4'h0, en: 4'hF});
        run_frame(2, 10, 16'h1111, 50, 16'h2222, 4'h0, 1'b1, -1);

        sb.push_back('{value: 16'h5555, dpm: 4'h0, en: 4'hF});
        run_frame(3, FRAME - 2, 16'h5555, -1, 16'h0000, 4'h0, 1'b1, -1);

        sb.push_back('{value: 16'h5555, dpm: 4'h0, en: 4'b0101});
        run_frame(4, -1, 16'h0000, -1, 16'h0000, 4'h0, 1'b0, -1);
        digit_en = 4'b0101;

        sb.push_back('{value: 16'h1234, dpm: 4'b0001, en: 4'b0101});
        run_frame(5, 30, 16'h1234, -1, 16'h0000, 4'b0001, 1'b1, -1);

        sb.push_back('{value: 16'h1234, dpm: 4'b0001, en: 4'b0101});
        run_frame(6, -1, 16'h0000, -1, 16'h0000, 4'h0, 1'b0, -1);

        // Reset lands while the count register holds 10 of digit 2.
        run_frame(7, -1, 16'h0000, -1, 16'h0000, 4'h0, 1'b0, 2 * DC + 9);
        repeat (2) @(negedge clk);
        check_blank("held rst");
        digit_en = 4'hF;
        sb.push_back('{value: 16'h0000, dpm: 4'h0, en: 4'hF});
        rst = 1'b0;
        run_frame(8, -1, 16'h0000, -1, 16'h0000, 4'h0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The block SHALL have parameter DIGIT_CYCLES, default 2500, giving clocks per digit slot (4 kHz slot rate at 10 MHz).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, giving the all-off cycles at the start of each slot; BLANK_CYCLES < DIGIT_CYCLES is required.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: a one-cycle strobe that writes wr_value and wr_dp.
REQ-006 The block SHALL have port wr_value, input, 16 bits: four hex nibbles, nibble k drives digit k.
REQ-007 The block SHALL have port wr_dp, input, 4 bits: decimal point k on when 1.
REQ-008 The block SHALL have port digit_en, input, 4 bits: digit k is enabled when bit k is 1; sampled live.
REQ-009 The block SHALL have port seg, output, 7 bits: active-low segment outputs, seg[0]=a through seg[6]=g.
REQ-010 The block SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-011 The block SHALL have port an, output, 4 bits: active-low digit anodes, an[0] the rightmost digit.
REQ-012 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse when digit 0 enters its blank phase.
REQ-013 The block SHALL have port updated, output, 1 bit: a one-cycle pulse when the display register loads new data.

Function
REQ-014 Slot counter SHALL count 0..DIGIT_CYCLES-1, then wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-015 The state machine SHALL have two states: BLANK when count < BLANK_CYCLES, otherwise DRIVE; the BLANK->DRIVE transition SHALL occur at count==BLANK_CYCLES, and DRIVE->BLANK at the wrap.
REQ-016 In BLANK: an=4'b1111, seg=7'h7F, dp=1.
REQ-017 In DRIVE for digit k with digit_en[k]=1: an[k]=0 and all other an bits=1; seg=hex decode of display nibble k; dp=~display_dp[k].
REQ-018 In DRIVE with digit_en[k]=0: outputs SHALL be as in BLANK.
REQ-019 Hex decode (active-low, g..a order) SHALL be: 0=1000000, 8=0000000, F=0001110, and standard patterns for all 16 values.
REQ-020 All outputs SHALL be registered; outputs SHALL reflect the state and digit index one cycle after the counter value that selects them.
REQ-021 wr_en SHALL load the pending register and set the pending flag; a later wr_en before the frame boundary SHALL overwrite it (last write wins).
REQ-022 The frame boundary is defined as the wrap from digit 3 to digit 0; at the boundary, if pending is set, display SHALL load from pending, pending SHALL clear, and updated SHALL pulse.
REQ-023 If wr_en coincides with the boundary, display SHALL load wr_value/wr_dp directly, pending SHALL end cleared, and updated SHALL pulse.
REQ-024 A digit_en change SHALL take effect at the next registered output update; a slot in progress SHALL NOT be restarted.

Reset
REQ-025 While rst is high: state=BLANK, digit=0, count=0, display=0, display_dp=0, pending=0, an=4'hF, seg=7'h7F, dp=1, frame_start=0, updated=0.
REQ-026 Assertion of rst mid-slot SHALL blank the outputs asynchronously.
REQ-027 After rst deasserts, frame_start SHALL pulse on the first clock edge, as digit 0 enters BLANK.

Configuration
REQ-028 With macro SEVENSEG_BRIGHTNESS_EN defined, the block SHALL add input bright (4 bits) and a 4-bit PWM phase counter that runs during DRIVE and resets at BLANK entry.
REQ-029 With SEVENSEG_BRIGHTNESS_EN defined, segments SHALL be lit only when phase <= bright, and otherwise driven as in BLANK; bright=15 gives full on and bright=0 gives 1/16 duty.
REQ-030 Without SEVENSEG_BRIGHTNESS_EN, port bright SHALL be absent and DRIVE SHALL be lit for the whole window.

Verification (DIGIT_CYCLES=20, BLANK_CYCLES=4)
REQ-031 Reset, then wr_en with wr_value=16'h0000 -> after the first boundary, each digit slot shows 4 blank cycles, then 16 cycles of seg=1000000, an rotating 1110, 1101, 1011, 0111; frame_start every 80 cycles.
REQ-032 wr_en with 16'hF08A mid-frame -> old value held until the boundary; then updated pulses and the digits show A, 8, 0, F on an[0..3].
REQ-033 Two writes, 16'h1111 then 16'h2222, in the same frame -> only 2222 is displayed, with exactly one updated pulse.
REQ-034 wr_en with 16'h5555 on the boundary cycle -> 5555 is displayed from that frame, updated pulses once, and pending reads 0.
REQ-035 digit_en=4'b0101, wr_dp=4'b0001 -> an[1] and an[3] stay high, and dp=0 only during the digit-0 DRIVE phase.
REQ-036 Assert rst at count 10 of digit 2 -> outputs blank immediately; after release, frame_start pulses on the first edge, and the display reads 0.
